// File: rtl/gate_tt_sweeper.sv
// gate_tt_sweeper: drives every input vector of a small combinational gate in
// ascending order, samples its output after a settle window, assembles the
// measured truth table and compares it against a latched expected table.
// Optional feature macro: GATE_TT_FIRST_FAIL_EN (adds fail_valid / fail_idx,
// the first vector whose sampled output disagrees with the expected table).
module gate_tt_sweeper #(
   parameter int N_IN       = 4,
   parameter int SETTLE_CYC = 2,
   localparam int TT_W      = 2**N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [TT_W-1:0] cfg_exp_tt,
   output logic [N_IN-1:0] gate_in,
   input  logic            gate_out,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] tt,
`ifdef GATE_TT_FIRST_FAIL_EN
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_idx,
`endif
   output logic            match
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [N_IN:0] IDX_LAST    = (N_IN+1)'(TT_W - 1);
   localparam logic [N_IN:0] IDX_ONE     = (N_IN+1)'(1);

   state_t          state_r, state_s;
   logic [N_IN:0]   idx_r, idx_s;
   logic [7:0]      settle_r, settle_s;
   logic [N_IN-1:0] gate_in_r, gate_in_s;
   logic [TT_W-1:0] exp_r, exp_s;
   logic [TT_W-1:0] tt_r, tt_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            match_r, match_s;
   logic            fail_valid_r, fail_valid_s;
   logic [N_IN-1:0] fail_idx_r, fail_idx_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode: settle window, sample, advance or finish.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_DRIVE;
            else       state_s = ST_IDLE;
         end
         ST_DRIVE: begin
            if (settle_r == SETTLE_LAST) state_s = ST_SAMPLE;
            else                         state_s = ST_DRIVE;
         end
         ST_SAMPLE: begin
            if (idx_r == IDX_LAST) state_s = ST_DONE;
            else                   state_s = ST_DRIVE;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath / output next values; everything lands in registers below.
   always_comb begin
      idx_s        = idx_r;
      settle_s     = settle_r;
      gate_in_s    = gate_in_r;
      exp_s        = exp_r;
      tt_s         = tt_r;
      match_s      = match_r;
      fail_valid_s = fail_valid_r;
      fail_idx_s   = fail_idx_r;
      busy_s       = (state_r != ST_IDLE);
      done_s       = (state_r == ST_DONE);
      case (state_r)
         ST_IDLE: begin
            gate_in_s = '0;
            if (start) begin
               exp_s        = cfg_exp_tt;
               tt_s         = '0;
               match_s      = 1'b0;
               idx_s        = '0;
               settle_s     = 8'd0;
               fail_valid_s = 1'b0;
               fail_idx_s   = '0;
            end else begin
               exp_s = exp_r;
            end
         end
         ST_DRIVE: begin
            if (settle_r == SETTLE_LAST) settle_s = settle_r;
            else                         settle_s = settle_r + 8'd1;
         end
         ST_SAMPLE: begin
            tt_s[idx_r[N_IN-1:0]] = gate_out;
            // Only the first disagreement is captured; later ones are ignored.
            if (!fail_valid_r && (gate_out != exp_r[idx_r[N_IN-1:0]])) begin
               fail_valid_s = 1'b1;
               fail_idx_s   = idx_r[N_IN-1:0];
            end else begin
               fail_valid_s = fail_valid_r;
            end
            if (idx_r != IDX_LAST) begin
               idx_s     = idx_r + IDX_ONE;
               settle_s  = 8'd0;
               gate_in_s = idx_s[N_IN-1:0];
            end else begin
               idx_s = idx_r;
            end
         end
         ST_DONE: begin
            // tt_r already holds the bit written in the final SAMPLE cycle.
            match_s   = (tt_r == exp_r);
            gate_in_s = '0;
         end
         default: begin
            gate_in_s = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r        <= '0;
         settle_r     <= 8'd0;
         gate_in_r    <= '0;
         exp_r        <= '0;
         tt_r         <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         match_r      <= 1'b0;
         fail_valid_r <= 1'b0;
         fail_idx_r   <= '0;
      end else begin
         idx_r        <= idx_s;
         settle_r     <= settle_s;
         gate_in_r    <= gate_in_s;
         exp_r        <= exp_s;
         tt_r         <= tt_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         match_r      <= match_s;
         fail_valid_r <= fail_valid_s;
         fail_idx_r   <= fail_idx_s;
      end
   end

   assign gate_in = gate_in_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign tt      = tt_r;
   assign match   = match_r;
`ifdef GATE_TT_FIRST_FAIL_EN
   assign fail_valid = fail_valid_r;
   assign fail_idx   = fail_idx_r;
`else
   logic unused_fail_s;
   assign unused_fail_s = fail_valid_r ^ (^fail_idx_r);
`endif

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// Randomized bench for gate_tt_sweeper: two instances (settle 2 and settle 1),
// each driving a table-lookup gate model; expectations come from a
// cycle-count / truth-table reference computed in the bench.
module tb_gate_tt_sweeper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [15:0] exp_a = 16'h0000, exp_b = 16'h0000;
   logic [15:0] gtt_a = 16'h0000, gtt_b = 16'h0000;
   logic [3:0]  gin_a, gin_b;
   logic        gout_a, gout_b;
   logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
   logic [15:0] tt_a, tt_b;
`ifdef GATE_TT_FIRST_FAIL_EN
   logic        fv_a, fv_b;
   logic [3:0]  fi_a, fi_b;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic sel = 1'b0;

   always #5 clk = ~clk;

   // Gate models: pure table lookup on the driven vector.
   assign gout_a = gtt_a[gin_a];
   assign gout_b = gtt_b[gin_b];

   gate_tt_sweeper #(.N_IN(4), .SETTLE_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_exp_tt(exp_a),
      .gate_in(gin_a), .gate_out(gout_a), .busy(busy_a), .done(done_a),
      .tt(tt_a),
`ifdef GATE_TT_FIRST_FAIL_EN
      .fail_valid(fv_a), .fail_idx(fi_a),
`endif
      .match(match_a));

   gate_tt_sweeper #(.N_IN(4), .SETTLE_CYC(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_exp_tt(exp_b),
      .gate_in(gin_b), .gate_out(gout_b), .busy(busy_b), .done(done_b),
      .tt(tt_b),
`ifdef GATE_TT_FIRST_FAIL_EN
      .fail_valid(fv_b), .fail_idx(fi_b),
`endif
      .match(match_b));

   wire [3:0]  o_gin   = sel ? gin_b   : gin_a;
   wire        o_busy  = sel ? busy_b  : busy_a;
   wire        o_done  = sel ? done_b  : done_a;
   wire        o_match = sel ? match_b : match_a;
   wire [15:0] o_tt    = sel ? tt_b    : tt_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v; else start_a = v;
   endtask

   task automatic set_exp(input logic [15:0] v);
      if (sel) exp_b = v; else exp_a = v;
   endtask

   // mode 0: plain sweep, 1: extra starts at cycle 10 and at the done cycle,
   // 2: expected table changed mid-sweep, 3: reset at cycle 20.
   task automatic run_sweep(input logic s, input logic [15:0] gtt,
                            input logic [15:0] expv, input int mode);
      int hold, lat, first_fail;
      logic exp_match;
      sel  = s;
      hold = s ? 2 : 3;
      lat  = 16 * hold + 1;
      exp_match  = (gtt == expv);
      first_fail = -1;
      for (int i = 15; i >= 0; i--) if (gtt[i] != expv[i]) first_fail = i;
      if (s) gtt_b = gtt; else gtt_a = gtt;
      @(negedge clk);
      set_exp(expv);
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
      for (int c = 0; c <= lat + 2; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (mode == 3 && c == 20) begin
            rst_n = 1'b0;
            #1;
            chk("rst_gate_in", {28'd0, o_gin}, 32'd0);
            chk("rst_busy", {31'd0, o_busy}, 32'd0);
            chk("rst_done", {31'd0, o_done}, 32'd0);
            chk("rst_tt", {16'd0, o_tt}, 32'd0);
            chk("rst_match", {31'd0, o_match}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(posedge clk);
               #1;
               chk("post_rst_done", {31'd0, o_done}, 32'd0);
               chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
            end
            return;
         end
         chk($sformatf("busy_c%0d", c), {31'd0, o_busy}, {31'd0, (c >= 1 && c <= lat)});
         chk($sformatf("done_c%0d", c), {31'd0, o_done}, {31'd0, (c == lat)});
         if (c < 16 * hold)
            chk($sformatf("gate_in_c%0d", c), {28'd0, o_gin}, 32'(c / hold));
         else if (c == lat - 1)
            chk("gate_in_last", {28'd0, o_gin}, 32'd15);
         else
            chk($sformatf("gate_in_idle_c%0d", c), {28'd0, o_gin}, 32'd0);
         if (c >= lat) begin
            chk($sformatf("tt_c%0d", c), {16'd0, o_tt}, {16'd0, gtt});
            chk($sformatf("match_c%0d", c), {31'd0, o_match}, {31'd0, exp_match});
`ifdef GATE_TT_FIRST_FAIL_EN
            chk("fail_valid", {31'd0, (s ? fv_b : fv_a)}, {31'd0, (first_fail >= 0)});
            if (first_fail >= 0)
               chk("fail_idx", {28'd0, (s ? fi_b : fi_a)}, 32'(first_fail));
`endif
         end
         // Disturbances, applied for the next edge.
         if (mode == 1 && (c == 9 || c == lat - 1)) begin
            set_start(1'b1);
            set_exp(16'($urandom));
         end else if (mode == 1 && (c == 10 || c == lat)) begin
            set_start(1'b0);
         end else if (mode == 2 && c == 5) begin
            set_exp(16'h0000);
         end
      end
   endtask

   initial begin
      logic [15:0] g, e;
      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0;
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      chk("reset_done", {31'd0, o_done}, 32'd0);
      chk("reset_tt", {16'd0, o_tt}, 32'd0);
      chk("reset_match", {31'd0, o_match}, 32'd0);
      chk("reset_gate_in", {28'd0, o_gin}, 32'd0);
      sel = 1'b1;
      chk("reset_b_gate_in", {28'd0, o_gin}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_sweep(1'b0, 16'h47FD, 16'h47FD, 0);
      run_sweep(1'b0, 16'hAAAA, 16'h47FD, 0);
      run_sweep(1'b0, 16'($urandom), 16'h47FD, 1);
      run_sweep(1'b0, 16'h47FD, 16'h47FD, 3);
      run_sweep(1'b0, 16'h47FD, 16'h47FD, 0);
      run_sweep(1'b1, 16'h47FD, 16'h47FD, 0);
      run_sweep(1'b0, 16'h47FD, 16'h47FD, 2);
      for (int r = 0; r < 8; r++) begin
         g = 16'($urandom);
         e = ($urandom_range(0, 1) == 0) ? g : (g ^ 16'($urandom_range(1, 65535)));
         run_sweep(1'($urandom_range(0, 1)), g, e, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
